// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared defaults for the programmable serial sequence detector and a helper
// that sizes the fill counter.
//   SEQ_LEN_DEF  default pattern length in bits
//   PAT_RST_DEF  default pattern loaded at reset
//   CNT_W_DEF    default match-counter width
//   fill_width() bits needed to hold a fill count of 0..seq_len
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam int unsigned SEQ_LEN_DEF = 4;
    localparam logic [3:0]  PAT_RST_DEF = 4'b1010;
    localparam int unsigned CNT_W_DEF   = 8;

    // The fill counter must represent SEQ_LEN itself, hence the +1.
    function automatic int unsigned fill_width(input int unsigned seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage : seq_det_pkg

// File: rtl/seq_det_prog_if.sv
// ---------------------------------------------------------------------------
// seq_det_prog_if
// Groups the detector's serial input, control and result signals.
//   in        serial data bit
//   en        sample qualifier
//   mode_ovl  1 = overlapping detection, 0 = non-overlapping
//   pat_load  load pat_in as the new pattern
//   pat_in    new pattern, MSB is the first bit received
//   z         one-cycle match pulse
//   match_cnt saturating match count
//   cnt_sat   match_cnt is all-ones
// Modports: master drives stimulus and observes results, slave is the detector.
// ---------------------------------------------------------------------------
interface seq_det_prog_if
    import seq_det_pkg::*;
#(
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) ();

    logic               in;
    logic               en;
    logic               mode_ovl;
    logic               pat_load;
    logic [SEQ_LEN-1:0] pat_in;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output in,
        output en,
        output mode_ovl,
        output pat_load,
        output pat_in,
        input  z,
        input  match_cnt,
        input  cnt_sat
    );

    modport slave (
        input  in,
        input  en,
        input  mode_ovl,
        input  pat_load,
        input  pat_in,
        output z,
        output match_cnt,
        output cnt_sat
    );

endinterface : seq_det_prog_if

// File: rtl/seq_det_prog_chk.sv
// ---------------------------------------------------------------------------
// seq_det_prog_chk
// Property checker for the sequence detector; observes only, drives nothing.
//   clk, rst   detector clock and synchronous active-low reset
//   en         sample qualifier
//   pat_load   pattern load strobe
//   z          match pulse
//   match_cnt  saturating match count
//   cnt_sat    saturation flag
//   fill       internal fill counter
// ---------------------------------------------------------------------------
module seq_det_prog_chk #(
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned FILL_W  = 3,
    parameter int unsigned CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    input logic              en,
    input logic              pat_load,
    input logic              z,
    input logic [CNT_W-1:0]  match_cnt,
    input logic              cnt_sat,
    input logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    // Fill never exceeds the pattern length.
    a_fill_range: assert property (@(posedge clk) disable iff (!rst)
        fill <= FILL_FULL);

    // Saturation flag always tracks an all-ones count.
    a_sat_decode: assert property (@(posedge clk) disable iff (!rst)
        cnt_sat == (&match_cnt));

    // An idle edge never produces a pulse.
    a_idle_no_z: assert property (@(posedge clk) disable iff (!rst)
        (rst && !en) |=> !z);

    // A pattern load edge never produces a pulse.
    a_load_no_z: assert property (@(posedge clk) disable iff (!rst)
        (rst && pat_load) |=> !z);

    // Outside reset the count never goes backwards.
    a_cnt_mono: assert property (@(posedge clk) disable iff (!rst)
        rst |=> (match_cnt >= $past(match_cnt)));

endmodule : seq_det_prog_chk

// File: rtl/seq_det_prog_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk    rising-edge clock
//   rst    synchronous active-low reset, clears the count
//   inc    add one on this edge (ignored once saturated)
//   count  current count (registered)
//   sat    count is all-ones (combinational decode of count)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         sat_s;

    // Saturation decode straight from the stored count.
    always_comb begin
        sat_s = &count_q;
    end

    // Next count: step only while below the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && !sat_s) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_s;

endmodule : sat_counter

// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
// Programmable serial sequence detector. Bits qualified by en shift into a
// history register; a registered pulse z is raised the cycle after the edge
// that completes the stored pattern. Overlapping or non-overlapping detection
// is selected per edge by mode_ovl. Matches are tallied in a saturating
// counter.
//   clk  rising-edge clock
//   rst  synchronous active-low reset (priority over pat_load and en)
//   bus  seq_det_prog_if.slave: in, en, mode_ovl, pat_load, pat_in -> z,
//        match_cnt, cnt_sat
// ---------------------------------------------------------------------------
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        SEQ_LEN = SEQ_LEN_DEF,
    parameter logic [SEQ_LEN-1:0] PAT_RST = SEQ_LEN'(PAT_RST_DEF),
    parameter int unsigned        CNT_W   = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst,
    seq_det_prog_if.slave bus
);

    localparam int unsigned        FILL_W    = fill_width(SEQ_LEN);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] hist_q;
    logic [SEQ_LEN-1:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [SEQ_LEN-1:0] pat_q;
    logic [SEQ_LEN-1:0] pat_d;
    logic               z_q;
    logic               z_d;

    logic [SEQ_LEN-1:0] hist_shift_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic               match_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               sat_s;

    // Candidate next-state values and the match decision made on them.
    // The fill qualification keeps stale reset history (all zeros) from
    // matching an all-zero pattern before SEQ_LEN real bits have arrived.
    always_comb begin
        hist_shift_s = {hist_q[SEQ_LEN-2:0], bus.in};
        if (fill_q == FILL_FULL) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + FILL_W'(1);
        end
        match_s = bus.en && !bus.pat_load
                  && (hist_shift_s == pat_q)
                  && (fill_inc_s == FILL_FULL);
    end

    // Next state for history, fill, pattern and pulse; load beats sampling.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        z_d    = 1'b0;
        if (bus.pat_load) begin
            // The bit on the load edge is discarded and progress restarts.
            pat_d  = bus.pat_in;
            fill_d = {FILL_W{1'b0}};
            z_d    = 1'b0;
        end else if (bus.en) begin
            hist_d = hist_shift_s;
            z_d    = match_s;
            // Non-overlap demands SEQ_LEN fresh bits after each hit; overlap
            // keeps the fill so the tail of this match can start the next.
            if (match_s && !bus.mode_ovl) begin
                fill_d = {FILL_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
            z_d    = 1'b0;
        end
    end

    // Detector state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= {SEQ_LEN{1'b0}};
            fill_q <= {FILL_W{1'b0}};
            pat_q  <= PAT_RST;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_s),
        .count (cnt_s),
        .sat   (sat_s)
    );

    seq_det_prog_chk #(
        .SEQ_LEN (SEQ_LEN),
        .FILL_W  (FILL_W),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .pat_load  (bus.pat_load),
        .z         (z_q),
        .match_cnt (cnt_s),
        .cnt_sat   (sat_s),
        .fill      (fill_q)
    );

    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_s;
    assign bus.cnt_sat   = sat_s;

endmodule : seq_det_prog

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a bit-queue model predicts z and the counts every cycle,
// and directed scenarios pin pulse positions with literal expectations.
module tb_seq_det_prog;
    import seq_det_pkg::*;

    localparam int L    = 4;
    localparam int CW_A = 8;
    localparam int CW_B = 2;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_det_prog_if #(.SEQ_LEN(L), .CNT_W(CW_A)) bus_a ();
    seq_det_prog_if #(.SEQ_LEN(L), .CNT_W(CW_B)) bus_b ();

    assign bus_b.in       = bus_a.in;
    assign bus_b.en       = bus_a.en;
    assign bus_b.mode_ovl = bus_a.mode_ovl;
    assign bus_b.pat_load = bus_a.pat_load;
    assign bus_b.pat_in   = bus_a.pat_in;

    seq_det_prog #(.SEQ_LEN(L), .PAT_RST(4'b1010), .CNT_W(CW_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seq_det_prog #(.SEQ_LEN(L), .PAT_RST(4'b1010), .CNT_W(CW_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: recent consumed bits, fresh-bit count, pattern, outputs.
    logic       m_hist[$];
    int         m_fresh;
    logic [3:0] m_pat;
    logic       m_z;
    int         m_cnt_a;
    int         m_cnt_b;
    logic       hit;

    // Directed-scenario logs taken from the DUT outputs.
    int   bit_idx;
    int   pulses_a[$];
    int   cnt_log_b[$];
    int   sat_log_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: last L consumed bits versus the pattern, gated by
    // having seen L fresh bits since the last restart.
    initial begin
        m_fresh = 0; m_pat = 4'b1010; m_z = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
        forever begin
            @(posedge clk);
            if (rst == 1'b0) begin
                m_hist.delete();
                m_fresh = 0;
                m_pat   = 4'b1010;
                m_z     = 1'b0;
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (bus_a.pat_load) begin
                m_pat   = bus_a.pat_in;
                m_fresh = 0;
                m_z     = 1'b0;
            end else if (bus_a.en) begin
                m_hist.push_back(bus_a.in);
                if (m_hist.size() > L) void'(m_hist.pop_front());
                if (m_fresh < L) m_fresh++;
                hit = (m_fresh == L);
                if (hit) begin
                    for (int i = 0; i < L; i++) begin
                        if (m_hist[i] != m_pat[L-1-i]) hit = 1'b0;
                    end
                end
                m_z = hit;
                if (hit) begin
                    if (m_cnt_a < MAX_A) m_cnt_a++;
                    if (m_cnt_b < MAX_B) m_cnt_b++;
                    if (!bus_a.mode_ovl) m_fresh = 0;
                end
            end else begin
                m_z = 1'b0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("z_a",   bus_a.z,         m_z);
                chk("cnt_a", bus_a.match_cnt, m_cnt_a);
                chk("sat_a", bus_a.cnt_sat,   m_cnt_a == MAX_A);
                chk("z_b",   bus_b.z,         m_z);
                chk("cnt_b", bus_b.match_cnt, m_cnt_b);
                chk("sat_b", bus_b.cnt_sat,   m_cnt_b == MAX_B);
            end
        end
    end

    // One clock of stimulus; returns just after the following falling edge.
    task automatic step(input logic b, input logic e, input logic ovl,
                        input logic ld, input logic [3:0] p, input logic r);
        rst            = r;
        bus_a.in       = b;
        bus_a.en       = e;
        bus_a.mode_ovl = ovl;
        bus_a.pat_load = ld;
        bus_a.pat_in   = p;
        @(negedge clk);
        if (r && !ld && e) bit_idx++;
        if (bus_a.z === 1'b1) pulses_a.push_back(bit_idx);
        if (bus_b.z === 1'b1) begin
            cnt_log_b.push_back(int'(bus_b.match_cnt));
            sat_log_b.push_back(int'(bus_b.cnt_sat));
        end
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input logic ovl);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ovl, 1'b0, 4'b0000, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        bit_idx = 0;
        pulses_a.delete();
        cnt_log_b.delete();
        sat_log_b.delete();
    endtask

    task automatic chk_pulses(input string name, input int n, input int p0, input int p1, input int p2);
        int exp_p[3];
        exp_p[0] = p0; exp_p[1] = p1; exp_p[2] = p2;
        chk({name, "_npulse"}, pulses_a.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({name, "_pos"}, (i < pulses_a.size()) ? pulses_a[i] : -1, exp_p[i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus_a.in = 1'b0; bus_a.en = 1'b0; bus_a.mode_ovl = 1'b1;
        bus_a.pat_load = 1'b0; bus_a.pat_in = 4'b0000;
        bit_idx = 0;
        @(negedge clk); #1;
        do_reset();
        chk_en = 1'b1;
        chk("rst_z",   bus_a.z,         0);
        chk("rst_cnt", bus_a.match_cnt, 0);
        chk("rst_sat", bus_a.cnt_sat,   0);

        // Long overlapping stream with three embedded matches.
        send_bits(32'b01010001101001010, 17, 1'b1);
        chk_pulses("t1", 3, 5, 12, 17);
        chk("t1_cnt_a", bus_a.match_cnt, 3);
        chk("t1_cnt_b", bus_b.match_cnt, 3);
        chk("t1_sat_b", bus_b.cnt_sat,   1);

        // Overlap versus non-overlap on 1010101.
        do_reset();
        send_bits(32'b1010101, 7, 1'b1);
        chk_pulses("t2_ovl", 2, 4, 6, 0);
        do_reset();
        send_bits(32'b1010101, 7, 1'b0);
        chk_pulses("t2_novl", 1, 4, 0, 0);

        // All-zero pattern; the bit on the load edge must be discarded.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1);
        send_bits(32'b000000, 6, 1'b1);
        chk_pulses("t3", 3, 4, 5, 6);

        // Narrow counter saturates: 1,2,3,3,3.
        do_reset();
        send_bits(32'b101010101010, 12, 1'b1);
        chk("t4_n", cnt_log_b.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t4_cnt_seq", (i < cnt_log_b.size()) ? cnt_log_b[i] : -1, (i < 2) ? i + 1 : 3);
            chk("t4_sat_seq", (i < sat_log_b.size()) ? sat_log_b[i] : -1, (i < 2) ? 0 : 1);
        end
        chk("t4_cnt_a", bus_a.match_cnt, 5);

        // Mid-sequence reset discards progress.
        do_reset();
        send_bits(32'b101, 3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        send_bits(32'b0, 1, 1'b1);
        send_bits(32'b1010, 4, 1'b1);
        chk_pulses("t5", 1, 8, 0, 0);

        // en=0 holds progress while in toggles.
        do_reset();
        send_bits(32'b101, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        send_bits(32'b0, 1, 1'b1);
        chk_pulses("t6", 1, 4, 0, 0);
        chk("t6_cnt_a", bus_a.match_cnt, 1);

        // Reset beats a simultaneous load: pattern stays 1010.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        send_bits(32'b1010, 4, 1'b1);
        chk_pulses("t7", 1, 4, 0, 0);

        // Load mid-sequence clears fill and drops the bit on that edge.
        do_reset();
        send_bits(32'b101, 3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
        send_bits(32'b0, 1, 1'b1);
        send_bits(32'b1010, 4, 1'b1);
        chk_pulses("t8", 1, 8, 0, 0);

        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_det_prog
